// File: rtl/memory_arbiter.sv
// Arbitrates instruction fetch and load/store requests onto one combinational Memory port.
// Grant to Valid is 2 cycles; at most one access every 2 cycles; fetch is forced through after STARVE_LIMIT data grants.
module memory_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetchReq,
    input  logic [31:0] fetchAddress,
    output logic        fetchGnt,
    output logic        fetchValid,
    output logic [31:0] fetchData,
    output logic        fetchMisaligned,
    input  logic        dataReq,
    input  logic [31:0] dataAddress,
    input  logic [31:0] dataWData,
    input  logic [2:0]  dataReadMode,
    input  logic [2:0]  dataWriteMode,
    input  logic        dataUnsigned,
    output logic        dataGnt,
    output logic        dataValid,
    output logic [31:0] dataRData,
    output logic [31:0] memAddress,
    output logic [31:0] memData,
    output logic [2:0]  memWriteMode,
    output logic [2:0]  memReadMode,
    output logic        memUnsignedLoad,
    input  logic [31:0] memDataOutput,
    output logic        busy
);
    localparam logic [2:0] MODE_NONE = 3'd0;
    localparam logic [2:0] MODE_WORD = 3'd3;
    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t        state, next_state;
    logic [CW-1:0] starve_count;
    logic          fetch_win, data_win;
    logic          lat_is_fetch;
    logic [31:0]   lat_addr, lat_wdata;
    logic [2:0]    lat_rmode, lat_wmode;
    logic          lat_unsigned;

    always_comb begin
        next_state = state;
        fetch_win  = 1'b0;
        data_win   = 1'b0;
        if (state == IDLE) begin
            // Data normally wins; fetch takes the slot when data is absent or fetch has waited too long.
            fetch_win = fetchReq && (!dataReq || starve_count == LIMIT);
            data_win  = dataReq && !fetch_win;
            if (fetchReq || dataReq)
                next_state = ACCESS;
        end else begin
            next_state = IDLE;
        end
    end

    assign fetchGnt = fetch_win && rst;
    assign dataGnt  = data_win && rst;
    assign busy     = (state == ACCESS);

    assign memAddress      = busy ? lat_addr : 32'd0;
    assign memData         = busy ? lat_wdata : 32'd0;
    assign memReadMode     = busy ? lat_rmode : MODE_NONE;
    assign memUnsignedLoad = busy ? lat_unsigned : 1'b0;
    // Gated by reset directly so an in-flight store can never commit while reset is asserted.
    assign memWriteMode    = (busy && rst) ? lat_wmode : MODE_NONE;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= IDLE;
            starve_count    <= '0;
            fetchValid      <= 1'b0;
            dataValid       <= 1'b0;
            fetchData       <= 32'd0;
            dataRData       <= 32'd0;
            fetchMisaligned <= 1'b0;
            lat_is_fetch    <= 1'b0;
            lat_addr        <= 32'd0;
            lat_wdata       <= 32'd0;
            lat_rmode       <= MODE_NONE;
            lat_wmode       <= MODE_NONE;
            lat_unsigned    <= 1'b0;
        end else begin
            state      <= next_state;
            fetchValid <= 1'b0;
            dataValid  <= 1'b0;

            if (fetch_win) begin
                lat_is_fetch <= 1'b1;
                lat_addr     <= fetchAddress;
                lat_wdata    <= 32'd0;
                lat_rmode    <= MODE_WORD;
                lat_wmode    <= MODE_NONE;
                lat_unsigned <= 1'b0;
            end else if (data_win) begin
                lat_is_fetch <= 1'b0;
                lat_addr     <= dataAddress;
                lat_wdata    <= dataWData;
                lat_rmode    <= dataReadMode;
                lat_wmode    <= dataWriteMode;
                lat_unsigned <= dataUnsigned;
            end

            if (state == IDLE) begin
                if (fetch_win || !fetchReq)
                    starve_count <= '0;
                else if (data_win && starve_count != LIMIT)
                    starve_count <= starve_count + 1'b1;
            end

            if (state == ACCESS) begin
                if (lat_is_fetch) begin
                    fetchValid      <= 1'b1;
                    fetchData       <= memDataOutput;
                    fetchMisaligned <= (lat_addr[1:0] != 2'b00);
                end else begin
                    dataValid <= 1'b1;
                    dataRData <= (lat_rmode == MODE_NONE) ? 32'd0 : memDataOutput;
                end
            end
        end
    end
endmodule
